// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - quadrant memory game round controller
// Grows a random sequence per level, plays it back frame-timed, then checks player selections.
module pattern_sequencer #(
  parameter int MAX_LEVEL      = 8,
  parameter int NUM_QUAD       = 4,
  parameter int SHOW_FRAMES    = 30,
  parameter int GAP_FRAMES     = 10,
  parameter int TIMEOUT_FRAMES = 300,
  localparam int LW = $clog2(MAX_LEVEL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          frame_tick,
  input  logic [2:0]    rand_num,
  input  logic          rand_valid,
  output logic          rand_req,
  input  logic          sel_valid,
  input  logic [2:0]    sel_quad,
  output logic          show_en,
  output logic [2:0]    show_quad,
  output logic          await_input,
  output logic [LW-1:0] level,
  output logic          win,
  output logic          lose
);

  localparam int IW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int MAXF = (SHOW_FRAMES > GAP_FRAMES) ?
                        ((SHOW_FRAMES > TIMEOUT_FRAMES) ? SHOW_FRAMES : TIMEOUT_FRAMES) :
                        ((GAP_FRAMES > TIMEOUT_FRAMES) ? GAP_FRAMES : TIMEOUT_FRAMES);
  localparam int CW = $clog2(MAXF + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHOW_ON, SHOW_GAP, INPUT, WIN, LOSE
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [2:0]     seq [MAX_LEVEL];

  logic [IW-1:0]  last_idx;
  logic [CW-1:0]  cnt_inc;
  logic           rand_ok;

  assign last_idx = IW'(level - LW'(1));
  assign cnt_inc  = cnt + CW'(1);
  assign rand_ok  = rand_valid && ({1'b0, rand_num} < 4'(NUM_QUAD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      level       <= '0;
      idx         <= '0;
      cnt         <= '0;
      rand_req    <= 1'b0;
      show_en     <= 1'b0;
      show_quad   <= 3'd0;
      await_input <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state    <= FETCH;
            level    <= LW'(1);
            idx      <= '0;
            cnt      <= '0;
            rand_req <= 1'b1;
            win      <= 1'b0;
            lose     <= 1'b0;
          end
        end

        FETCH: begin
          if (rand_ok) begin
            seq[last_idx] <= rand_num;
            state         <= SHOW_ON;
            idx           <= '0;
            cnt           <= '0;
            rand_req      <= 1'b0;
            show_en       <= 1'b1;
            // seq[0] is being written this cycle on level 1, so bypass it
            show_quad     <= (level == LW'(1)) ? rand_num : seq[0];
          end
        end

        SHOW_ON: begin
          if (frame_tick) begin
            if (cnt_inc == CW'(SHOW_FRAMES)) begin
              state     <= SHOW_GAP;
              cnt       <= '0;
              show_en   <= 1'b0;
              show_quad <= 3'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        SHOW_GAP: begin
          if (frame_tick) begin
            if (cnt_inc == CW'(GAP_FRAMES)) begin
              cnt <= '0;
              if (idx == last_idx) begin
                state       <= INPUT;
                idx         <= '0;
                await_input <= 1'b1;
              end else begin
                state     <= SHOW_ON;
                idx       <= idx + IW'(1);
                show_en   <= 1'b1;
                show_quad <= seq[idx + IW'(1)];
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        INPUT: begin
          // a selection takes precedence over a coincident timeout tick
          if (sel_valid) begin
            if (sel_quad != seq[idx]) begin
              state       <= LOSE;
              lose        <= 1'b1;
              await_input <= 1'b0;
              cnt         <= '0;
            end else if (idx != last_idx) begin
              idx <= idx + IW'(1);
              cnt <= '0;
            end else if (level == LW'(MAX_LEVEL)) begin
              state       <= WIN;
              win         <= 1'b1;
              await_input <= 1'b0;
              cnt         <= '0;
            end else begin
              state       <= FETCH;
              level       <= level + LW'(1);
              rand_req    <= 1'b1;
              await_input <= 1'b0;
              cnt         <= '0;
            end
          end else if (frame_tick) begin
            if (cnt_inc == CW'(TIMEOUT_FRAMES)) begin
              state       <= LOSE;
              lose        <= 1'b1;
              await_input <= 1'b0;
              cnt         <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] rand_num = 3'd0;
  logic       rand_valid = 1'b0;
  logic       rand_req;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_quad = 3'd0;
  logic       show_en;
  logic [2:0] show_quad;
  logic       await_input;
  logic [1:0] level;
  logic       win;
  logic       lose;

  int n_checks = 0;
  int n_pass   = 0;

  pattern_sequencer #(
    .MAX_LEVEL(2), .NUM_QUAD(4), .SHOW_FRAMES(2), .GAP_FRAMES(1), .TIMEOUT_FRAMES(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .rand_num(rand_num), .rand_valid(rand_valid), .rand_req(rand_req),
    .sel_valid(sel_valid), .sel_quad(sel_quad), .show_en(show_en),
    .show_quad(show_quad), .await_input(await_input), .level(level),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic feed(input logic [2:0] v);
    rand_num = v; rand_valid = 1'b1; step(); rand_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
    end
  endtask

  task automatic pick(input logic [2:0] q);
    sel_quad = q; sel_valid = 1'b1; step(); sel_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    step();
    check("reset_outs", {29'd0, rand_req, show_en, await_input}, 32'd0);
    check("reset_level", {30'd0, level}, 32'd0);
    check("reset_flags", {30'd0, win, lose}, 32'd0);

    // reset in the middle of SHOW_ON
    pulse_start();
    feed(3'd1);
    check("pre_rst_show", {31'd0, show_en}, 32'd1);
    rst = 1'b1; #1;
    check("async_rst_show", {31'd0, show_en}, 32'd0);
    step(); rst = 1'b0; step();
    check("post_rst_level", {30'd0, level}, 32'd0);
    check("post_rst_outs", {26'd0, rand_req, show_en, show_quad, await_input}, 32'd0);

    // level 1: reject 5, accept 2, playback
    pulse_start();
    check("start_level", {30'd0, level}, 32'd1);
    check("start_req", {31'd0, rand_req}, 32'd1);
    feed(3'd5);
    check("rej_req", {31'd0, rand_req}, 32'd1);
    check("rej_show", {31'd0, show_en}, 32'd0);
    feed(3'd2);
    check("l1_show", {28'd0, show_en, show_quad}, {28'd0, 1'b1, 3'd2});
    check("l1_req_drop", {31'd0, rand_req}, 32'd0);
    tick(1);
    check("l1_show_t1", {31'd0, show_en}, 32'd1);
    tick(1);
    check("l1_gap", {28'd0, show_en, show_quad}, 32'd0);
    check("l1_gap_wait", {31'd0, await_input}, 32'd0);
    tick(1);
    check("l1_await", {31'd0, await_input}, 32'd1);

    // level 2: seq {2,1}, win
    pick(3'd2);
    check("l2_level", {30'd0, level}, 32'd2);
    check("l2_req", {31'd0, rand_req}, 32'd1);
    check("l2_await_drop", {31'd0, await_input}, 32'd0);
    feed(3'd1);
    check("l2_show0", {28'd0, show_en, show_quad}, {28'd0, 1'b1, 3'd2});
    tick(2);
    check("l2_gap0", {31'd0, show_en}, 32'd0);
    tick(1);
    check("l2_show1", {28'd0, show_en, show_quad}, {28'd0, 1'b1, 3'd1});
    tick(3);
    check("l2_await", {31'd0, await_input}, 32'd1);
    pick(3'd2);
    check("l2_mid_await", {30'd0, await_input, win}, 32'd2);
    pick(3'd1);
    check("win_set", {30'd0, win, await_input}, 32'd2);
    step(); step();
    check("win_held", {29'd0, win, level}, {29'd0, 1'b1, 2'd2});

    // wrong selection loses
    pulse_start();
    check("restart_win", {29'd0, win, level}, {29'd0, 1'b0, 2'd1});
    feed(3'd3);
    tick(3);
    check("l1b_await", {31'd0, await_input}, 32'd1);
    pick(3'd0);
    check("lose_set", {30'd0, lose, await_input}, 32'd2);
    step();
    check("lose_held", {29'd0, lose, level}, {29'd0, 1'b1, 2'd1});
    pulse_start();
    check("lose_clear", {29'd0, lose, level}, {29'd0, 1'b0, 2'd1});

    // timeout, with start ignored during INPUT
    feed(3'd0);
    tick(3);
    pulse_start();
    check("start_ignored", {28'd0, await_input, rand_req, level}, {28'd0, 1'b1, 1'b0, 2'd1});
    tick(4);
    check("pre_timeout", {30'd0, await_input, lose}, 32'd2);
    tick(1);
    check("timeout_lose", {30'd0, await_input, lose}, 32'd1);

    // selection on the timeout tick wins over the timeout
    pulse_start();
    feed(3'd2);
    tick(3);
    tick(4);
    sel_quad = 3'd2; sel_valid = 1'b1; frame_tick = 1'b1;
    step();
    sel_valid = 1'b0; frame_tick = 1'b0;
    check("sel_on_timeout", {28'd0, lose, rand_req, level}, {28'd0, 1'b0, 1'b1, 2'd2});

    // sel_valid during SHOW_ON is ignored
    feed(3'd3);
    pick(3'd0);
    check("sel_in_show", {27'd0, lose, show_en, show_quad}, {27'd0, 1'b0, 1'b1, 3'd2});
    tick(3);
    check("seq1_show", {28'd0, show_en, show_quad}, {28'd0, 1'b1, 3'd3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
